// File: rtl/step_ctrl.sv
// Pipeline clock-enable generator: full/divided/single-step/halt run modes plus PC breakpoint.
// Optional feature macro: STEP_CTRL_BP_EN builds the breakpoint FSM, skip flag and sco_bp_hit.
module step_ctrl #(
    parameter int DIV_W  = 24,
    parameter int DEB_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              sci_clk,
    input  logic              sci_rst,
    input  logic [1:0]        sci_mode,
    input  logic [DIV_W-1:0]  sci_div,
    input  logic              sci_step_btn,
    input  logic [ADDR_W-1:0] sci_pc,
    input  logic [ADDR_W-1:0] sci_bp_addr,
    input  logic              sci_bp_en,
    input  logic              sci_resume,
    output logic              sco_tick,
    output logic              sco_halted,
    output logic              sco_bp_hit,
    output logic [15:0]       sco_tick_count
);

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_DIV  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    logic [1:0]       r_mode_q;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_tick;
    logic [15:0]      r_tick_cnt;

    logic w_mode_chg;
    logic w_div_hit;
    logic w_deb_diff;
    logic w_deb_full;
    logic w_deb_fall;
    logic w_req;
    logic w_tick_nxt;

    // A mode change restarts the divided period, so the edge of the change never requests.
    assign w_mode_chg = (sci_mode != r_mode_q);
    assign w_div_hit  = !w_mode_chg && (r_div_cnt >= sci_div);
    assign w_deb_diff = (r_sync2 != r_deb);
    assign w_deb_full = &r_deb_cnt;
    assign w_deb_fall = w_deb_diff && w_deb_full && !r_sync2;

    always_comb begin
        w_req = 1'b0;
        case (sci_mode)
            MODE_FULL: w_req = 1'b1;
            MODE_DIV:  w_req = w_div_hit;
            MODE_STEP: w_req = w_deb_fall;
            default:   w_req = 1'b0;
        endcase
    end

    // Divider and debouncer run in every mode; only the request decode looks at the mode.
    always_ff @(posedge sci_clk) begin
        if (!sci_rst) begin
            r_mode_q  <= sci_mode;
            r_div_cnt <= '0;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
        end else begin
            r_mode_q <= sci_mode;
            if (w_mode_chg || w_div_hit) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            r_sync1 <= sci_step_btn;
            r_sync2 <= r_sync1;
            if (!w_deb_diff) begin
                r_deb_cnt <= '0;
            end else if (w_deb_full) begin
                r_deb     <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

`ifdef STEP_CTRL_BP_EN
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HALT_BP = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_skip;
    logic   w_skip_nxt;
    logic   r_bp_hit;
    logic   w_bp_hit_nxt;
    logic   w_bp_match;

    // Skip lets the instruction sitting at the breakpoint execute once after resume.
    assign w_bp_match = w_req && sci_bp_en && (sci_pc == sci_bp_addr) && !r_skip;

    always_comb begin
        w_state_nxt  = r_state;
        w_skip_nxt   = r_skip;
        w_bp_hit_nxt = r_bp_hit;
        w_tick_nxt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_bp_match) begin
                    w_state_nxt  = ST_HALT_BP;
                    w_bp_hit_nxt = 1'b1;
                end else begin
                    w_tick_nxt = w_req;
                    if (w_req) begin
                        w_skip_nxt = 1'b0;
                    end
                end
            end
            ST_HALT_BP: begin
                if (sci_resume) begin
                    w_state_nxt  = ST_RUN;
                    w_skip_nxt   = 1'b1;
                    w_bp_hit_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge sci_clk) begin
        if (!sci_rst) begin
            r_state  <= ST_RUN;
            r_skip   <= 1'b0;
            r_bp_hit <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_skip   <= w_skip_nxt;
            r_bp_hit <= w_bp_hit_nxt;
        end
    end

    assign sco_halted = (r_state == ST_HALT_BP) || (sci_mode == MODE_HALT);
    assign sco_bp_hit = r_bp_hit;
`else
    logic w_unused;

    assign w_unused   = ^{sci_pc, sci_bp_addr, sci_bp_en, sci_resume};
    assign w_tick_nxt = w_req;
    assign sco_halted = (sci_mode == MODE_HALT);
    assign sco_bp_hit = 1'b0;
`endif

    always_ff @(posedge sci_clk) begin
        if (!sci_rst) begin
            r_tick     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_tick <= w_tick_nxt;
            if (r_tick) begin
                r_tick_cnt <= r_tick_cnt + 16'd1;
            end
        end
    end

    assign sco_tick       = r_tick;
    assign sco_tick_count = r_tick_cnt;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: random and directed stimulus against a cycle-level reference model.
module tb_step_ctrl;

    localparam int DIV_W  = 8;
    localparam int DEB_W  = 4;
    localparam int ADDR_W = 16;
`ifdef STEP_CTRL_BP_EN
    localparam bit BP_BUILT = 1'b1;
`else
    localparam bit BP_BUILT = 1'b0;
`endif

    logic              sci_clk = 1'b0;
    logic              sci_rst;
    logic [1:0]        sci_mode;
    logic [DIV_W-1:0]  sci_div;
    logic              sci_step_btn;
    logic [ADDR_W-1:0] sci_pc;
    logic [ADDR_W-1:0] sci_bp_addr;
    logic              sci_bp_en;
    logic              sci_resume;
    logic              sco_tick;
    logic              sco_halted;
    logic              sco_bp_hit;
    logic [15:0]       sco_tick_count;

    step_ctrl #(
        .DIV_W (DIV_W),
        .DEB_W (DEB_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .sci_clk       (sci_clk),
        .sci_rst       (sci_rst),
        .sci_mode      (sci_mode),
        .sci_div       (sci_div),
        .sci_step_btn  (sci_step_btn),
        .sci_pc        (sci_pc),
        .sci_bp_addr   (sci_bp_addr),
        .sci_bp_en     (sci_bp_en),
        .sci_resume    (sci_resume),
        .sco_tick      (sco_tick),
        .sco_halted    (sco_halted),
        .sco_bp_hit    (sco_bp_hit),
        .sco_tick_count(sco_tick_count)
    );

    always #5 sci_clk = ~sci_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state, advanced once per rising edge from the spec's rules.
    int m_cnt;
    int m_prev_mode;
    int m_run;
    int m_count;
    bit m_s1, m_s2, m_deb;
    bit m_tick, m_hbp, m_skip, m_hit;
    bit pc_follow = 1'b0;

    task automatic model_edge();
        bit div_req;
        bit fall;
        bit req;
        bit s;
        if (!sci_rst) begin
            m_cnt = 0; m_prev_mode = int'(sci_mode); m_run = 0; m_count = 0;
            m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1;
            m_tick = 1'b0; m_hbp = 1'b0; m_skip = 1'b0; m_hit = 1'b0;
            return;
        end
        if (m_tick) m_count = (m_count + 1) % 65536;
        div_req = 1'b0;
        if (int'(sci_mode) != m_prev_mode) begin
            m_cnt = 0;
        end else if (m_cnt >= int'(sci_div)) begin
            div_req = 1'b1;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        m_prev_mode = int'(sci_mode);
        s = m_s2; m_s2 = m_s1; m_s1 = sci_step_btn;
        fall = 1'b0;
        if (s == m_deb) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == (1 << DEB_W)) begin
                m_deb = s;
                m_run = 0;
                fall = (s == 1'b0);
            end
        end
        case (sci_mode)
            2'b00:   req = 1'b1;
            2'b01:   req = div_req;
            2'b10:   req = fall;
            default: req = 1'b0;
        endcase
        if (!BP_BUILT) begin
            m_tick = req;
        end else if (m_hbp) begin
            m_tick = 1'b0;
            if (sci_resume) begin
                m_hbp = 1'b0; m_skip = 1'b1; m_hit = 1'b0;
            end
        end else if (req && sci_bp_en && (sci_pc == sci_bp_addr) && !m_skip) begin
            m_hbp = 1'b1; m_hit = 1'b1; m_tick = 1'b0;
        end else begin
            m_tick = req;
            if (req) m_skip = 1'b0;
        end
    endtask

    task automatic step(input bit chk);
        @(posedge sci_clk);
        model_edge();
        @(negedge sci_clk);
        if (chk) begin
            check_eq("tick", sco_tick, m_tick);
            check_eq("count", sco_tick_count, m_count[15:0]);
            check_eq("halted", sco_halted, m_hbp || (sci_mode == 2'b11));
            check_eq("bp_hit", sco_bp_hit, m_hit);
        end
        if (pc_follow && m_tick) sci_pc = sci_pc + 16'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    int base;
    int btn_left;

    initial begin
        sci_rst = 1'b0; sci_mode = 2'b00; sci_div = '0; sci_step_btn = 1'b1;
        sci_pc = '0; sci_bp_addr = 16'h0010; sci_bp_en = 1'b0; sci_resume = 1'b0;

        // Reset, then full speed.
        run(3);
        check_eq("rst_tick", sco_tick, 0);
        check_eq("rst_count", sco_tick_count, 0);
        sci_rst = 1'b1;
        run(6);
        check_eq("full_count6", sco_tick_count, 5);

        // Divided mode, period 4, then divisor lowered below the running count.
        sci_mode = 2'b01; sci_div = 8'd3;
        run(13);
        sci_div = 8'd1;
        run(8);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) sci_div = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) sci_mode = 2'($urandom_range(0, 1));
            step(1'b1);
        end

        // Single-step with debouncing.
        sci_mode = 2'b10; sci_step_btn = 1'b1;
        run(4);
        base = m_count;
        sci_step_btn = 1'b0; run(3);
        sci_step_btn = 1'b1; run(20);
        check_eq("step_short", sco_tick_count - 16'(base), 0);
        sci_step_btn = 1'b0; run(40);
        check_eq("step_long", sco_tick_count - 16'(base), 1);
        sci_step_btn = 1'b1; run(40);
        check_eq("step_release", sco_tick_count - 16'(base), 1);
        btn_left = 0;
        for (int i = 0; i < 300; i++) begin
            if (btn_left == 0) begin
                sci_step_btn = ~sci_step_btn;
                btn_left = $urandom_range(1, 30);
            end
            btn_left--;
            step(1'b1);
        end
        sci_step_btn = 1'b1; run(30);

        // Halt mode swallows a press; no step is queued for later.
        sci_mode = 2'b11;
        base = m_count;
        sci_step_btn = 1'b0; run(40);
        check_eq("halt_flag", sco_halted, 1);
        sci_step_btn = 1'b1; run(40);
        sci_mode = 2'b10; run(10);
        check_eq("halt_noqueue", sco_tick_count - 16'(base), 0);
        sci_mode = 2'b00; run(5);

        // Breakpoint hit, resume with simultaneous matching request, bp_en drop while halted.
        pc_follow = 1'b1; sci_pc = 16'h0008; sci_bp_addr = 16'h0010; sci_bp_en = 1'b1;
        sci_resume = 1'b1; step(1'b1); sci_resume = 1'b0;
        run(20);
        sci_resume = 1'b1; step(1'b1); sci_resume = 1'b0;
        run(10);
        sci_pc = 16'h000C; run(15);
        sci_bp_en = 1'b0; run(5);
        sci_resume = 1'b1; step(1'b1); sci_resume = 1'b0;
        run(5);

        // Mixed random operation.
        sci_bp_addr = 16'h0020; sci_bp_en = 1'b1; sci_pc = 16'h0018;
        btn_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) sci_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) sci_div = 8'($urandom_range(0, 4));
            if (btn_left == 0) begin
                sci_step_btn = ~sci_step_btn;
                btn_left = $urandom_range(1, 30);
            end
            btn_left--;
            if (sci_pc > 16'h0030) sci_pc = 16'h0018;
            sci_resume = ($urandom_range(0, 15) == 0);
            step(1'b1);
        end
        sci_resume = 1'b0; sci_step_btn = 1'b1;

        // Reset while sitting at a breakpoint.
        sci_mode = 2'b00; sci_pc = 16'h001E;
        run(10);
        sci_rst = 1'b0;
        run(2);
        check_eq("rst_bp_tick", sco_tick, 0);
        check_eq("rst_bp_halted", sco_halted, 0);
        check_eq("rst_bp_hit", sco_bp_hit, 0);
        check_eq("rst_bp_count", sco_tick_count, 0);

        // Tick counter wrap.
        pc_follow = 1'b0; sci_bp_en = 1'b0; sci_rst = 1'b1;
        for (int i = 0; i < 65536; i++) step(1'b0);
        check_eq("wrap_ffff", sco_tick_count, 16'hFFFF);
        step(1'b1);
        check_eq("wrap_zero", sco_tick_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
